ch_pack: RTL and testbench
==========================

// Module: ch_pack
// PURPOSE
//  Downstream of the channel sequencer in the RX path. Snapshots all per-channel I/Q decimator outputs on strobe.
//  Then emits one 32-bit {I,Q} word per clock for channels 1..num_ch into the RX FIFO write port.
//  Marks the first word of each frame. Detects FIFO-full and busy-strobe overruns.
// PARAMETERS
//  MAX_CH  4   number of physical channels present on data_in (1..15)
//  SW      16  sample width of each I and Q component
//  CNT_W   16  width of the saturating overrun counter
// PORTS
//  clk          in   1              system clock; single clock domain
//  reset        in   1              asynchronous, active-low reset (asserted when 0)
//  strobe       in   1              one-cycle pulse: new sample set valid on data_in
//  num_ch       in   4              active channels per frame; sampled on accepted strobe
//  data_in      in   MAX_CH*2*SW    ch k at [(k*2*SW)+:2*SW], layout {I,Q}, k=0..MAX_CH-1
//  fifo_full    in   1              RX FIFO cannot accept a write this cycle
//  fifo_we      out  1              FIFO write enable
//  fifo_wdata   out  2*SW           {I,Q} of current channel
//  fifo_sof     out  1              high with fifo_we on first word of a frame
//  channel      out  4              channel being written (1..n), 0 when idle
//  busy         out  1              frame in progress
//  ovr_flag     out  1              sticky overrun indicator
//  ovr_cnt      out  CNT_W          saturating count of overrun events
//  ovr_clr      in   1              synchronous clear of ovr_flag and ovr_cnt
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; all outputs 0; holding regs 0; n_lat=0.
//  FSM IDLE:
//   - strobe && num_ch!=0: latch data_in into hold regs.
//   - n_lat = min(num_ch, MAX_CH).
//   - channel<=1; go SEND.
//  - strobe && num_ch==0: ignored; no write, no flag.
//  FSM SEND, each cycle:
//   - If !fifo_full: fifo_we=1, fifo_wdata=hold[channel-1], fifo_sof=(channel==1).
//   - If channel==n_lat: go IDLE, channel<=0; else channel++.
//   - If fifo_full: no write; abort frame, channel<=0, IDLE; overrun event.
//  Outputs fifo_we/wdata/sof/channel are registered.
//   - Strobe at cycle t -> first write at t+1.
//   - Last write at t+n_lat; busy high t+1..t+n_lat.
//  Strobe while SEND: sample set dropped, frame continues unaffected; overrun event.
//   - On the last SEND cycle, a strobe is also dropped; no back-to-back frames in v1.
//  Overrun event: ovr_flag<=1; ovr_cnt++ saturating at all-ones.
//   - At most one event counted per cycle.
//  ovr_clr:
//   - Clears flag and count.
//   - If coincident with an event, clear wins for flag; count becomes 1.
//  Reset mid-frame: immediate abort, no further writes.
// STRUCTURE
//  Package ch_pkg holds:
//   - CH_W=4 channel index width.
//   - State enum {IDLE, SEND}.
//   - Function ch_clamp(num_ch, MAX_CH).
//  Sub-module ovr_counter (CNT_W): sticky flag + saturating counter with inc/clr inputs.
//  Hold regs and FSM inline in ch_pack.
// TESTING
//  1. MAX_CH=4, num_ch=3, strobe, fifo_full=0:
//     - writes at t+1..t+3, channel 1,2,3.
//     - sof only on first write; wdata equals snapshot taken at t.
//  2. num_ch=0, strobe -> no fifo_we, busy=0, ovr_cnt unchanged.
//  3. num_ch=9 with MAX_CH=4 -> exactly 4 writes, channel 1..4.
//  4. fifo_full asserted at t+2 of a 4-ch frame:
//     - one write only; frame aborted.
//     - ovr_flag=1, ovr_cnt=1, next strobe starts a clean frame with sof.
//  5. Strobe during SEND:
//     - original frame completes unchanged; new set dropped.
//     - ovr_cnt+1; ovr_clr then returns flag/count to 0.
//  6. reset pulled low at t+2: outputs 0 asynchronously, no writes after release until next strobe.

Source files
------------

// File: rtl/ch_pkg.sv
// Shared definitions for the RX channel packer.
//   CH_W      width of every channel index / channel count
//   state_e   packer FSM states
//   ch_clamp  limits a requested channel count to the number of physical channels
package ch_pkg;

    localparam int CH_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Returns min(num_ch, max_ch); max_ch is always at most 15 for this block.
    function automatic logic [CH_W-1:0] ch_clamp(input logic [CH_W-1:0] num_ch,
                                                 input int unsigned     max_ch);
        if ({{(32-CH_W){1'b0}}, num_ch} > max_ch) begin
            return CH_W'(max_ch);
        end
        return num_ch;
    endfunction

endpackage

// File: rtl/ch_pack_ovr_counter.sv
// Sticky overrun flag plus saturating overrun event counter.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   inc          one overrun event this cycle
//   clr          synchronous clear of flag and count
//   flag         sticky overrun indicator
//   cnt          event count, saturates at all-ones
module ovr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic             flag,
    output logic [CNT_W-1:0] cnt
);

    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    // A clear coinciding with an event leaves the flag low but still
    // records that single event in the count.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (clr) begin
            flag_d = 1'b0;
            cnt_d  = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            flag_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag = flag_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/ch_pack.sv
// RX channel packer. On an accepted strobe, snapshots every channel's {I,Q}
// sample and then writes one word per clock for channels 1..n into the RX
// FIFO, flagging the first word of the frame. A full FIFO aborts the frame;
// a full FIFO or a strobe arriving mid-frame is counted as an overrun.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   strobe, num_ch       new sample set / active channel count
//   data_in              channel k at [k*2*SW +: 2*SW], {I,Q}
//   fifo_full            FIFO cannot take a write this cycle
//   fifo_we/wdata/sof    FIFO write port and start-of-frame marker
//   channel              channel being written (1..n), 0 when idle
//   busy                 frame in progress (FSM is in SEND)
//   ovr_flag, ovr_cnt    sticky overrun flag and saturating count
//   ovr_clr              synchronous clear of the overrun state
//
// Handshake: fifo_we is the only valid; fifo_full is the inverse of ready. A
// word is transferred exactly in a cycle with fifo_we=1, and fifo_we is never
// asserted while fifo_full=1.
module ch_pack
    import ch_pkg::*;
#(
    parameter int MAX_CH = 4,
    parameter int SW     = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   strobe,
    input  logic [CH_W-1:0]        num_ch,
    input  logic [MAX_CH*2*SW-1:0] data_in,
    input  logic                   fifo_full,
    output logic                   fifo_we,
    output logic [2*SW-1:0]        fifo_wdata,
    output logic                   fifo_sof,
    output logic [CH_W-1:0]        channel,
    output logic                   busy,
    output logic                   ovr_flag,
    output logic [CNT_W-1:0]       ovr_cnt,
    input  logic                   ovr_clr
);

    state_e                  state_q, state_d;
    logic [MAX_CH*2*SW-1:0]  hold_q,  hold_d;
    logic [CH_W-1:0]         n_lat_q, n_lat_d;
    logic [CH_W-1:0]         channel_q, channel_d;
    logic [2*SW-1:0]         wdata_q, wdata_d;
    logic                    sof_q,   sof_d;

    logic                    accept;
    logic                    last;
    logic                    ovr_inc;
    logic [2*SW-1:0]         next_word;

    assign accept = (state_q == IDLE) && strobe && (num_ch != '0);
    assign last   = (channel_q == n_lat_q);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (fifo_full || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot word for the channel after the current one (channel_q is
    // 1-based, so it is directly the 0-based index of the next channel).
    always_comb begin
        next_word = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (channel_q == CH_W'(k)) begin
                next_word = hold_q[k*2*SW +: 2*SW];
            end
        end
    end

    // Datapath / output register inputs.
    always_comb begin
        hold_d    = hold_q;
        n_lat_d   = n_lat_q;
        channel_d = channel_q;
        wdata_d   = wdata_q;
        sof_d     = 1'b0;
        ovr_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d    = data_in;
                    n_lat_d   = ch_clamp(num_ch, MAX_CH);
                    channel_d = CH_W'(1);
                    wdata_d   = data_in[2*SW-1:0];
                    sof_d     = 1'b1;
                end
            end
            SEND: begin
                // A strobe here is dropped, including on the last word.
                ovr_inc = fifo_full || strobe;
                if (fifo_full || last) begin
                    channel_d = '0;
                    wdata_d   = '0;
                end else begin
                    channel_d = channel_q + CH_W'(1);
                    wdata_d   = next_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q    <= '0;
            n_lat_q   <= '0;
            channel_q <= '0;
            wdata_q   <= '0;
            sof_q     <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            n_lat_q   <= n_lat_d;
            channel_q <= channel_d;
            wdata_q   <= wdata_d;
            sof_q     <= sof_d;
        end
    end

    ovr_counter #(
        .CNT_W(CNT_W)
    ) u_ovr (
        .clk   (clk),
        .reset (reset),
        .inc   (ovr_inc),
        .clr   (ovr_clr),
        .flag  (ovr_flag),
        .cnt   (ovr_cnt)
    );

    // Word, channel and marker are registered; the write enable is gated by
    // the current fifo_full so a word is never pushed into a full FIFO.
    assign fifo_we    = (state_q == SEND) && !fifo_full;
    assign fifo_sof   = sof_q && fifo_we;
    assign fifo_wdata = wdata_q;
    assign channel    = channel_q;
    assign busy       = (state_q == SEND);

endmodule

// File: tb/tb_ch_pack.sv
module tb_ch_pack;

    localparam int MAX_CH = 4;
    localparam int SW     = 16;
    localparam int CNT_W  = 4;
    localparam int DW     = MAX_CH * 2 * SW;

    localparam logic [DW-1:0] D1 = {32'h4444_4004, 32'h3333_3003, 32'h2222_2002, 32'h1111_1001};
    localparam logic [DW-1:0] D2 = {32'h8888_8008, 32'h7777_7007, 32'h6666_6006, 32'h5555_5005};

    logic             clk;
    logic             reset;
    logic             strobe;
    logic [3:0]       num_ch;
    logic [DW-1:0]    data_in;
    logic             fifo_full;
    logic             fifo_we;
    logic [2*SW-1:0]  fifo_wdata;
    logic             fifo_sof;
    logic [3:0]       channel;
    logic             busy;
    logic             ovr_flag;
    logic [CNT_W-1:0] ovr_cnt;
    logic             ovr_clr;

    int n_vec;
    int n_miss;

    ch_pack #(
        .MAX_CH(MAX_CH),
        .SW    (SW),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strobe     (strobe),
        .num_ch     (num_ch),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_wdata (fifo_wdata),
        .fifo_sof   (fifo_sof),
        .channel    (channel),
        .busy       (busy),
        .ovr_flag   (ovr_flag),
        .ovr_cnt    (ovr_cnt),
        .ovr_clr    (ovr_clr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic          strobe;
        logic [3:0]    num_ch;
        logic [DW-1:0] din;
        logic          full;
        logic          clr;
        logic          we;
        logic [31:0]   wd;
        logic          sof;
        logic [3:0]    ch;
        logic          busy;
        logic          flag;
        logic [3:0]    cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic s, logic [3:0] n, logic [DW-1:0] d, logic f, logic c,
                                logic we, logic [31:0] wd, logic sof, logic [3:0] ch,
                                logic b, logic fl, logic [3:0] cnt);
        vec_t v;
        v.strobe = s;  v.num_ch = n; v.din = d; v.full = f; v.clr = c;
        v.we = we; v.wd = wd; v.sof = sof; v.ch = ch; v.busy = b; v.flag = fl; v.cnt = cnt;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(logic s, logic [3:0] n, logic [DW-1:0] d, logic f, logic c);
        strobe    = s;
        num_ch    = n;
        data_in   = d;
        fifo_full = f;
        ovr_clr   = c;
    endtask

    // Advance to just after the next active edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic cmp(string tag, string fld, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    task automatic check(string tag, logic we, logic [31:0] wd, logic chk_wd, logic sof,
                         logic [3:0] ch, logic b, logic fl, logic [3:0] cnt);
        n_vec++;
        cmp(tag, "fifo_we", 32'(fifo_we), 32'(we));
        if (chk_wd) cmp(tag, "fifo_wdata", fifo_wdata, wd);
        cmp(tag, "fifo_sof", 32'(fifo_sof), 32'(sof));
        cmp(tag, "channel", 32'(channel), 32'(ch));
        cmp(tag, "busy", 32'(busy), 32'(b));
        cmp(tag, "ovr_flag", 32'(ovr_flag), 32'(fl));
        cmp(tag, "ovr_cnt", 32'(ovr_cnt), 32'(cnt));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        drive(1'b0, 4'd0, '0, 1'b0, 1'b0);

        //         strb num din full clr | we  wdata          sof ch busy flag cnt
        // basic 3-channel frame; input changes after strobe must not leak in
        vq.push_back(mk(0, 0, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, D2, 0, 0,  1, 32'h1111_1001,  1, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, D2, 0, 0,  1, 32'h2222_2002,  0, 2, 1, 0, 0));
        vq.push_back(mk(0, 0, D2, 0, 0,  1, 32'h3333_3003,  0, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, D2, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        // num_ch = 0 strobe is ignored
        vq.push_back(mk(1, 0, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        // num_ch = 9 clamps to 4
        vq.push_back(mk(1, 9, D2, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h5555_5005,  1, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h6666_6006,  0, 2, 1, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h7777_7007,  0, 3, 1, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h8888_8008,  0, 4, 1, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        // fifo_full at t+2 aborts a 4-channel frame, then a clean frame follows
        vq.push_back(mk(1, 4, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h1111_1001,  1, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, D1, 1, 0,  0, 32'h0,          0, 2, 1, 0, 0));
        vq.push_back(mk(1, 2, D2, 0, 0,  0, 32'h0,          0, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h5555_5005,  1, 1, 1, 1, 1));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h6666_6006,  0, 2, 1, 1, 1));
        vq.push_back(mk(0, 0, D1, 0, 0,  0, 32'h0,          0, 0, 0, 1, 1));
        // strobes mid-frame and on the last word are dropped and counted
        vq.push_back(mk(1, 3, D1, 0, 0,  0, 32'h0,          0, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, D1, 0, 0,  1, 32'h1111_1001,  1, 1, 1, 1, 1));
        vq.push_back(mk(1, 2, D2, 0, 0,  1, 32'h2222_2002,  0, 2, 1, 1, 1));
        vq.push_back(mk(1, 4, D2, 0, 0,  1, 32'h3333_3003,  0, 3, 1, 1, 2));
        vq.push_back(mk(0, 0, D2, 0, 0,  0, 32'h0,          0, 0, 0, 1, 3));
        vq.push_back(mk(0, 0, D2, 0, 1,  0, 32'h0,          0, 0, 0, 1, 3));
        vq.push_back(mk(0, 0, D2, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        // single-channel frame; clear coincident with an event
        vq.push_back(mk(1, 1, D1, 0, 0,  0, 32'h0,          0, 0, 0, 0, 0));
        vq.push_back(mk(1, 3, D2, 0, 1,  1, 32'h1111_1001,  1, 1, 1, 0, 0));
        vq.push_back(mk(0, 0, D2, 0, 0,  0, 32'h0,          0, 0, 0, 0, 1));
        // full on the very first word: no write, no sof, abort
        vq.push_back(mk(1, 2, D1, 1, 0,  0, 32'h0,          0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, D1, 1, 0,  0, 32'h0,          0, 1, 1, 0, 1));
        vq.push_back(mk(0, 0, D1, 0, 0,  0, 32'h0,          0, 0, 0, 1, 2));

        // reset state
        #3;
        check("reset_hold", 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        next_cycle();
        reset = 1'b1;
        #2;
        check("reset_release", 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        // table
        for (int i = 0; i < vq.size(); i++) begin
            next_cycle();
            drive(vq[i].strobe, vq[i].num_ch, vq[i].din, vq[i].full, vq[i].clr);
            #2;
            check($sformatf("vec%0d", i), vq[i].we, vq[i].wd, vq[i].we, vq[i].sof,
                  vq[i].ch, vq[i].busy, vq[i].flag, vq[i].cnt);
        end

        // reset pulled low at t+2 of a 4-channel frame
        next_cycle();
        drive(1'b1, 4'd4, D1, 1'b0, 1'b0);
        #2;
        check("rst_seq_t", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2);
        next_cycle();
        drive(1'b0, 4'd0, D1, 1'b0, 1'b0);
        #2;
        check("rst_seq_t1", 1'b1, 32'h1111_1001, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2);
        next_cycle();
        #2;
        check("rst_seq_t2", 1'b1, 32'h2222_2002, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 4'd2);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async", 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("rst_idle%0d", i), 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
            next_cycle();
        end
        drive(1'b1, 4'd2, D2, 1'b0, 1'b0);
        #2;
        check("rst_restart_t", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        next_cycle();
        drive(1'b0, 4'd0, D1, 1'b0, 1'b0);
        #2;
        check("rst_restart_t1", 1'b1, 32'h5555_5005, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0);
        next_cycle();
        #2;
        check("rst_restart_t2", 1'b1, 32'h6666_6006, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 4'd0);
        next_cycle();
        #2;
        check("rst_restart_end", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        // counter saturation: 17 abort events into a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            drive(1'b1, 4'd4, D1, 1'b0, 1'b0);
            next_cycle();
            drive(1'b0, 4'd0, D1, 1'b1, 1'b0);
        end
        next_cycle();
        drive(1'b0, 4'd0, D1, 1'b0, 1'b0);
        #2;
        check("sat_cnt", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15);
        next_cycle();
        drive(1'b0, 4'd0, D1, 1'b0, 1'b1);
        next_cycle();
        drive(1'b0, 4'd0, D1, 1'b0, 1'b0);
        #2;
        check("sat_clr", 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
